// File: rtl/ducq_nco_mixer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ducq_nco_mixer_if
//  Description : Bundle of the Q-branch NCO/mixer control, sample, octant-ROM
//                and product signals. The slave modport is the mixer itself;
//                the master modport is everything around it (control, sample
//                source, both octant ROMs and the downstream combiner).
//  Revision    : 1.0  initial release
// ============================================================================
interface ducq_nco_mixer_if #(
    parameter int PH_W = 24,
    parameter int D_W  = 12
);
    logic [PH_W-1:0]       fcw;
    logic [11:0]           phase_ofs;
    logic                  nco_clr;
    logic                  in_valid;
    logic signed [D_W-1:0] in_data;
    logic [8:0]            rom_addr;
    logic [7:0]            sin_q;
    logic [7:0]            cos_q;
    logic                  out_valid;
    logic signed [D_W-1:0] out_data;

    modport master (
        output fcw, phase_ofs, nco_clr, in_valid, in_data, sin_q, cos_q,
        input  rom_addr, out_valid, out_data
    );

    modport slave (
        input  fcw, phase_ofs, nco_clr, in_valid, in_data, sin_q, cos_q,
        output rom_addr, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/ducq_nco_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : ducq_nco_mixer
//  Description : Q-branch NCO and mixer. Accumulates phase, folds it into an
//                octant ROM address, rebuilds a signed sine from the sin/cos
//                octant ROM magnitudes and multiplies the Q sample by it.
//                Three-stage pipeline, fixed latency of 3 cycles.
//  Options     : DUCQ_NCO_DITHER_EN - adds 12-bit LFSR phase dither below
//                the 12 phase bits used for the ROM lookup.
//  Revision    : 1.0  initial release
// ============================================================================
module ducq_nco_mixer #(
    parameter int PH_W = 24,
    parameter int D_W  = 12
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ducq_nco_mixer_if.slave    bus
);
    // Product width: D_W-bit sample times 9-bit signed sine.
    localparam int P_W = D_W + 9;

    // Phase accumulator.
    logic [PH_W-1:0]       acc_q, acc_d;
    // Stage 1: folded address, octant controls, sample.
    logic [8:0]            rom_addr_q, rom_addr_d;
    logic                  s1_cos_q, s1_cos_d;
    logic                  s1_neg_q, s1_neg_d;
    logic signed [D_W-1:0] s1_data_q, s1_data_d;
    logic                  s1_valid_q, s1_valid_d;
    // Stage 2: signed sine, sample.
    logic signed [8:0]     s2_s_q, s2_s_d;
    logic signed [D_W-1:0] s2_data_q, s2_data_d;
    logic                  s2_valid_q, s2_valid_d;
    // Stage 3: rounded product.
    logic signed [D_W-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    // Phase the current sample sees (zero when cleared in the same cycle).
    logic [PH_W-1:0]       acc_eff;
    logic [11:0]           ph;
    logic [2:0]            oct;
    logic [8:0]            a;
    logic [7:0]            mag;
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] rnd;

`ifdef DUCQ_NCO_DITHER_EN
    logic [11:0] lfsr_q, lfsr_d;
    logic [23:0] dith_sum;

    // Dither LFSR steps once per accepted sample; nco_clr leaves it alone.
    always_comb begin
        lfsr_d = lfsr_q;
        if (bus.in_valid) begin
            lfsr_d = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
        end
    end

    // Dither register, seeded to a nonzero pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 12'hACE;
        else     lfsr_q <= lfsr_d;
    end
`endif

    // Sample phase from the pre-update accumulator, then octant folding.
    always_comb begin
        acc_eff = bus.nco_clr ? '0 : acc_q;
`ifdef DUCQ_NCO_DITHER_EN
        dith_sum = acc_eff[PH_W-1 -: 24] + {12'd0, lfsr_q};
        ph       = dith_sum[23:12] + bus.phase_ofs;
`else
        ph       = acc_eff[PH_W-1 -: 12] + bus.phase_ofs;
`endif
        oct      = ph[11:9];
        a        = ph[8:0];
    end

    // Accumulator advance / clear.
    always_comb begin
        acc_d = acc_q;
        if (bus.nco_clr)       acc_d = bus.in_valid ? bus.fcw : '0;
        else if (bus.in_valid) acc_d = acc_q + bus.fcw;
    end

    // Stage 1: odd octants mirror the address; idle cycles hold the data.
    always_comb begin
        rom_addr_d = rom_addr_q;
        s1_cos_d   = s1_cos_q;
        s1_neg_d   = s1_neg_q;
        s1_data_d  = s1_data_q;
        s1_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            rom_addr_d = oct[0] ? ~a : a;
            s1_cos_d   = oct[0] ^ oct[1];
            s1_neg_d   = oct[2];
            s1_data_d  = bus.in_data;
        end
    end

    // Stage 2: pick the ROM magnitude and apply the half-circle sign.
    always_comb begin
        mag        = s1_cos_q ? bus.cos_q : bus.sin_q;
        s2_s_d     = s2_s_q;
        s2_data_d  = s2_data_q;
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            s2_s_d    = s1_neg_q ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
            s2_data_d = s1_data_q;
        end
    end

    // Stage 3: multiply, round half-up, drop 8 fraction bits.
    always_comb begin
        prod        = P_W'(s2_data_q) * P_W'(s2_s_q);
        rnd         = prod + P_W'(128);
        out_data_d  = out_data_q;
        out_valid_d = s2_valid_q;
        if (s2_valid_q) out_data_d = rnd[D_W+7:8];
    end

    // All pipeline and NCO state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            rom_addr_q  <= '0;
            s1_cos_q    <= 1'b0;
            s1_neg_q    <= 1'b0;
            s1_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            s2_s_q      <= '0;
            s2_data_q   <= '0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            rom_addr_q  <= rom_addr_d;
            s1_cos_q    <= s1_cos_d;
            s1_neg_q    <= s1_neg_d;
            s1_data_q   <= s1_data_d;
            s1_valid_q  <= s1_valid_d;
            s2_s_q      <= s2_s_d;
            s2_data_q   <= s2_data_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ducq_nco_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ducq_nco_mixer
//  Description : Self-checking bench for ducq_nco_mixer. Models both octant
//                ROMs as tables and predicts every output from the phase /
//                octant rules with plain integer arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ducq_nco_mixer;
    localparam int PH_W = 24;
    localparam int D_W  = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ducq_nco_mixer_if #(.PH_W(PH_W), .D_W(D_W)) bus ();

    ducq_nco_mixer #(.PH_W(PH_W), .D_W(D_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Octant ROM contents: round(f(a*pi/2048)*256), saturated to 255.
    logic [7:0] sin_tab [512];
    logic [7:0] cos_tab [512];
    assign bus.sin_q = sin_tab[bus.rom_addr];
    assign bus.cos_q = cos_tab[bus.rom_addr];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [PH_W-1:0] m_acc;
    logic [8:0]      m_addr;
    bit              q_v[$];
    int              q_d[$];

    function automatic int ref_sine(input int ph, output int addr);
        int o, a, mag;
        o = ph / 512;
        a = ph % 512;
        addr = (o % 2 == 1) ? 511 - a : a;
        case (o % 4)
            0:       mag = int'(sin_tab[a]);
            1:       mag = int'(cos_tab[511 - a]);
            2:       mag = int'(cos_tab[a]);
            default: mag = int'(sin_tab[511 - a]);
        endcase
        return (o >= 4) ? -mag : mag;
    endfunction

    task automatic model_reset();
        m_acc  = '0;
        m_addr = '0;
        q_v.delete();
        q_d.delete();
        repeat (2) begin
            q_v.push_back(1'b0);
            q_d.push_back(0);
        end
    endtask

    // One clock: drive inputs, predict, advance, compare outputs.
    task automatic cyc(input bit v, input int d, input bit clr);
        logic [PH_W-1:0] base;
        int ph, s, addr, prod, ev_d;
        bit ev_v;
        base = clr ? '0 : m_acc;
        if (clr)    m_acc = v ? bus.fcw : '0;
        else if (v) m_acc = m_acc + bus.fcw;
        ph   = (int'(base[PH_W-1 -: 12]) + int'(bus.phase_ofs)) % 4096;
        s    = ref_sine(ph, addr);
        prod = d * s;
        q_v.push_back(v);
        q_d.push_back((prod + 128) >>> 8);
        bus.in_valid = v;
        bus.in_data  = D_W'(d);
        bus.nco_clr  = clr;
        @(posedge clk);
        #1;
        if (v) m_addr = 9'(addr);
        ev_v = q_v.pop_front();
        ev_d = q_d.pop_front();
        n_cmp++;
        if (bus.out_valid !== ev_v) begin
            n_err++;
            $display("FAIL out_valid: got %b expected %b at %0t", bus.out_valid, ev_v, $time);
        end
        if (ev_v) begin
            n_cmp++;
            if (bus.out_data !== D_W'(ev_d)) begin
                n_err++;
                $display("FAIL out_data: got %0d expected %0d at %0t", bus.out_data, ev_d, $time);
            end
        end
        n_cmp++;
        if (bus.rom_addr !== m_addr) begin
            n_err++;
            $display("FAIL rom_addr: got %h expected %h at %0t", bus.rom_addr, m_addr, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.rom_addr !== '0) begin
            n_err++;
            $display("FAIL %s: got valid=%b data=%0d addr=%h expected 0/0/0",
                     tag, bus.out_valid, bus.out_data, bus.rom_addr);
        end
    endtask

    task automatic test_reset();
        #2;
        check_zero_outputs("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc(1'b0, 0, 1'b1);
        bus.fcw = 24'h123456;
        bus.phase_ofs = 12'h321;
        repeat (4) cyc(1'b1, $signed(D_W'($urandom)), 1'b0);
        // Asynchronous reset with samples in flight.
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #2;
        check_zero_outputs("reset_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (4) cyc(1'b0, 0, 1'b0);
    endtask

    task automatic test_phase_points();
        bus.fcw = '0;
        bus.phase_ofs = 12'h000;
        cyc(1'b0, 0, 1'b1);
        repeat (6) cyc(1'b1, 1000, 1'b0);
        n_cmp++;
        if (bus.out_data !== 12'sd0) begin
            n_err++;
            $display("FAIL phase0: got %0d expected 0", bus.out_data);
        end
        bus.phase_ofs = 12'h400;
        repeat (4) cyc(1'b1, 1000, 1'b0);
        n_cmp++;
        if (bus.out_data !== 12'sd996) begin
            n_err++;
            $display("FAIL phase90: got %0d expected 996", bus.out_data);
        end
        bus.phase_ofs = 12'hC00;
        repeat (4) cyc(1'b1, 1000, 1'b0);
        n_cmp++;
        if (bus.out_data !== -12'sd996) begin
            n_err++;
            $display("FAIL phase270: got %0d expected -996", bus.out_data);
        end
        bus.phase_ofs = 12'h400;
        repeat (4) cyc(1'b1, -2048, 1'b0);
        n_cmp++;
        if (bus.out_data !== -12'sd2040) begin
            n_err++;
            $display("FAIL phase90_min: got %0d expected -2040", bus.out_data);
        end
    endtask

    task automatic test_sweep();
        bus.fcw = 24'h001000;
        bus.phase_ofs = 12'h000;
        cyc(1'b0, 0, 1'b1);
        for (int i = 0; i <= 4100; i++) begin
            cyc(1'b1, $signed(D_W'($urandom)), 1'b0);
            if (i == 512) begin
                n_cmp++;
                if (bus.rom_addr !== 9'h1FF) begin
                    n_err++;
                    $display("FAIL sweep_512: got %h expected 1ff", bus.rom_addr);
                end
            end
        end
    endtask

    task automatic test_gapped();
        bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.fcw = 24'h0A5000;
        bus.phase_ofs = 12'h0F0;
        foreach (pat[i]) cyc(pat[i], $signed(D_W'($urandom)), 1'b0);
        repeat (4) cyc(1'b0, 0, 1'b0);
    endtask

    task automatic test_nco_clr();
        bus.fcw = 24'h100000;
        bus.phase_ofs = 12'h000;
        repeat (3) cyc(1'b1, $signed(D_W'($urandom)), 1'b0);
        cyc(1'b1, 1500, 1'b1);
        repeat (5) cyc(1'b1, $signed(D_W'($urandom)), 1'b0);
        cyc(1'b0, 0, 1'b1);
        repeat (3) cyc(1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                bus.fcw = PH_W'($urandom);
                bus.phase_ofs = 12'($urandom);
            end
            cyc(($urandom % 4) != 0, $signed(D_W'($urandom)), ($urandom % 32) == 0);
        end
    endtask

    initial begin
        for (int a = 0; a < 512; a++) begin
            int sv, cv;
            sv = $rtoi($sin(a * 3.14159265358979 / 2048.0) * 256.0 + 0.5);
            cv = $rtoi($cos(a * 3.14159265358979 / 2048.0) * 256.0 + 0.5);
            sin_tab[a] = (sv > 255) ? 8'hFF : 8'(sv);
            cos_tab[a] = (cv > 255) ? 8'hFF : 8'(cv);
        end
        bus.fcw       = '0;
        bus.phase_ofs = '0;
        bus.nco_clr   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        model_reset();
        test_reset();
        test_phase_points();
        test_sweep();
        test_gapped();
        test_nco_clr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
